// File: rtl/debounce_edge_pkg.sv
// Shared sizing for the debounce_edge slice.
// Define SYNC3_EN for a 3-flop synchroniser (adds one cycle of latency); default is 2 flops.
package debounce_edge_pkg;

`ifdef SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

endpackage

// File: rtl/debounce_bit.sv
// One input bit: synchroniser chain, debounce counter, registered level and rise/fall pulses.
// Synchroniser depth comes from debounce_edge_pkg (SYNC3_EN selects 3 flops).
module debounce_bit
    import debounce_edge_pkg::*;
#(
    parameter int   DEBOUNCE = 16,
    parameter int   CNTWIDTH = 5,
    parameter logic INIT     = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam logic [CNTWIDTH-1:0] CNT_LAST = CNTWIDTH'(DEBOUNCE - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CNTWIDTH-1:0]    cnt;
    logic                   s;

    assign s = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            sync  <= {SYNC_STAGES{INIT}};
            level <= INIT;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            // Plain shift: nothing may sit between the synchroniser flops.
            sync <= {sync[SYNC_STAGES-2:0], i};
            rise <= 1'b0;
            fall <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt != CNT_LAST) begin
                cnt <= cnt + CNTWIDTH'(1);
            end else begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end
        end
    end

endmodule

// File: rtl/debounce_edge.sv
// Per-bit synchronise + debounce + edge pulse array; wiring only, one debounce_bit per input.
// SYNC3_EN (see debounce_edge_pkg) deepens every synchroniser by one flop.
module debounce_edge
    import debounce_edge_pkg::*;
#(
    parameter int   DATAWIDTH = 1,
    parameter int   DEBOUNCE  = 16,
    parameter int   CNTWIDTH  = 5,
    parameter logic INIT      = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATAWIDTH-1:0] i,
    output logic [DATAWIDTH-1:0] level,
    output logic [DATAWIDTH-1:0] rise,
    output logic [DATAWIDTH-1:0] fall
);

    for (genvar b = 0; b < DATAWIDTH; b++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE (DEBOUNCE),
            .CNTWIDTH (CNTWIDTH),
            .INIT     (INIT)
        ) u_bit (
            .clk   (clk),
            .reset (reset),
            .i     (i[b]),
            .level (level[b]),
            .rise  (rise[b]),
            .fall  (fall[b])
        );
    end

endmodule

// File: tb/tb_debounce_edge.sv
// Self-checking bench for debounce_edge: vector table, directed corner sequences, random vs model.
// Latency expectations follow SYNC3_EN when the build defines it.
module tb_debounce_edge;

    localparam int DW  = 2;
    localparam int DEB = 4;
    localparam int CW  = 3;
`ifdef SYNC3_EN
    localparam int SYN = 3;
`else
    localparam int SYN = 2;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] i = '0;
    logic [DW-1:0] i1 = 2'b11;
    logic [DW-1:0] level, rise, fall;
    logic [DW-1:0] level1, rise1, fall1;

    always #5 clk = ~clk;

    debounce_edge #(.DATAWIDTH(DW), .DEBOUNCE(DEB), .CNTWIDTH(CW), .INIT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .i(i), .level(level), .rise(rise), .fall(fall));

    debounce_edge #(.DATAWIDTH(DW), .DEBOUNCE(DEB), .CNTWIDTH(CW), .INIT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .i(i1), .level(level1), .rise(rise1), .fall(fall1));

    int tests = 0;
    int fails = 0;
    int cyc_idx = 0;
    int rcnt [DW];
    int fcnt [DW];
    int rise_at [DW];
    int both_fall = 0;

    // Reference model: input samples delayed by the synchroniser depth; a bit's level
    // flips once the last DEB synced samples all disagree with it.
    logic [DW-1:0] ihist [$];
    logic [DW-1:0] shist [$];
    logic [DW-1:0] m_level, m_rise, m_fall;

    task automatic model_edge(input logic r, input logic [DW-1:0] v);
        logic [DW-1:0] s;
        bool_loop: begin end
        if (r) begin
            ihist.delete();
            shist.delete();
            for (int k = 0; k < SYN; k++) ihist.push_back('0);
            m_level = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            s = ihist[SYN-1];
            ihist.push_front(v);
            void'(ihist.pop_back());
            shist.push_front(s);
            if (shist.size() > DEB) void'(shist.pop_back());
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < DW; b++) begin
                int ndiff;
                ndiff = 0;
                foreach (shist[k]) if (shist[k][b] != m_level[b]) ndiff++;
                if (ndiff == DEB) begin
                    m_level[b] = ~m_level[b];
                    m_rise[b]  = m_level[b];
                    m_fall[b]  = ~m_level[b];
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc_idx, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic clr_counts();
        for (int b = 0; b < DW; b++) begin
            rcnt[b] = 0; fcnt[b] = 0; rise_at[b] = -1;
        end
        both_fall = 0;
        cyc_idx = 0;
    endtask

    // One clock: drive, let the edge happen, advance the model, compare away from the edge.
    task automatic cyc(input logic r, input logic [DW-1:0] v);
        reset = r;
        i = v;
        @(posedge clk);
        model_edge(r, v);
        #1;
        chk("level", level, m_level);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("rise_fall_excl", rise & fall, '0);
        if (!r) begin
            chk("init1_level", level1, 2'b11);
            chk("init1_pulse", rise1 | fall1, 2'b00);
        end
        for (int b = 0; b < DW; b++) begin
            if (rise[b]) begin rcnt[b]++; rise_at[b] = cyc_idx; end
            if (fall[b]) fcnt[b]++;
        end
        if (fall == 2'b11) both_fall++;
        cyc_idx++;
    endtask

    typedef struct {
        logic          rst;
        logic [DW-1:0] iv;
        logic [DW-1:0] lvl;
        logic [DW-1:0] rs;
        logic [DW-1:0] fl;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    initial begin
        // Table: reset row, then i[0] rises at edge E (row 1); flip at E+3+SYN.
        tbl[0] = '{rst: 1'b1, iv: 2'b00, lvl: 2'b00, rs: 2'b00, fl: 2'b00};
        for (int r = 1; r < NV; r++) begin
            tbl[r].rst = 1'b0;
            tbl[r].iv  = 2'b01;
            tbl[r].lvl = (r - 1 >= 3 + SYN) ? 2'b01 : 2'b00;
            tbl[r].rs  = (r - 1 == 3 + SYN) ? 2'b01 : 2'b00;
            tbl[r].fl  = 2'b00;
        end

        // Reset, then hold 00: nothing moves.
        clr_counts();
        cyc(1'b1, 2'b00);
        cyc(1'b1, 2'b00);
        for (int k = 0; k < 8; k++) cyc(1'b0, 2'b00);
        chk_int("idle_rises", rcnt[0] + rcnt[1], 0);

        for (int r = 0; r < NV; r++) begin
            cyc(tbl[r].rst, tbl[r].iv);
            chk("tbl_level", level, tbl[r].lvl);
            chk("tbl_rise", rise, tbl[r].rs);
            chk("tbl_fall", fall, tbl[r].fl);
        end

        // Glitch of DEB-1 synced cycles is rejected.
        cyc(1'b1, 2'b00);
        clr_counts();
        for (int k = 0; k < DEB - 1; k++) cyc(1'b0, 2'b01);
        for (int k = 0; k < 10; k++) cyc(1'b0, 2'b00);
        chk_int("short_pulse_rises", rcnt[0], 0);

        // Exactly DEB synced cycles propagates once (and then falls back).
        clr_counts();
        for (int k = 0; k < DEB; k++) cyc(1'b0, 2'b01);
        for (int k = 0; k < 12; k++) cyc(1'b0, 2'b00);
        chk_int("exact_pulse_rises", rcnt[0], 1);
        chk_int("exact_pulse_falls", fcnt[0], 1);

        // Bounce on bit 1: 1,0 then a run of 1s starting at index 2.
        cyc(1'b1, 2'b00);
        clr_counts();
        cyc(1'b0, 2'b10);
        cyc(1'b0, 2'b00);
        for (int k = 0; k < 10; k++) cyc(1'b0, 2'b10);
        chk_int("bounce_rises", rcnt[1], 1);
        chk_int("bounce_rise_at", rise_at[1], 2 + SYN + DEB - 1);

        // Both bits settle high, then drop together.
        for (int k = 0; k < 4; k++) cyc(1'b0, 2'b11);
        clr_counts();
        for (int k = 0; k < 10; k++) cyc(1'b0, 2'b00);
        chk_int("dual_fall", both_fall, 1);
        chk("dual_fall_level", level, 2'b00);

        // Reset while bit 0 is one step from flipping: pending pulse discarded.
        clr_counts();
        for (int k = 0; k < SYN + DEB - 1; k++) cyc(1'b0, 2'b01);
        cyc(1'b1, 2'b01);
        chk("midreset_level", level, 2'b00);
        chk_int("midreset_no_rise", rcnt[0], 0);
        clr_counts();
        for (int k = 0; k < 12; k++) cyc(1'b0, 2'b01);
        chk_int("midreset_rises", rcnt[0], 1);
        chk_int("midreset_rise_at", rise_at[0], SYN + DEB - 1);

        // Random: variable hold lengths, occasional reset.
        for (int n = 0; n < 400; n++) begin
            logic [DW-1:0] v;
            int hold;
            v = DW'($urandom_range(0, 3));
            hold = $urandom_range(1, 7);
            for (int k = 0; k < hold; k++) cyc($urandom_range(0, 199) == 0, v);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
